// File: rtl/dcache_port_arbiter.sv
// Two-requester arbiter for the single data-cache request port.
// Core (0) and debug/DMA (1) share the port; contention resolved round-robin.
module dcache_port_arbiter #(
    parameter int ADDR_W = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              read0,
    input  logic              read1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic              io0,
    input  logic              io1,
    output logic              ack0,
    output logic              ack1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] aq,
    output logic              read,
    output logic [31:0]       wq,
    output logic              selDCache,
    output logic              selDCacheIO,
    input  logic              done,
    input  logic              wrq,
    input  logic [31:0]       rqDCache,
    output logic [7:0]        waitCnt
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t state;
    logic   owner;
    logic   rr;
    logic   grant1;
    logic   otherReq;

    // Requester 1 wins only if it is alone or the pointer favours it.
    assign grant1   = req1 & (~req0 | rr);
    assign otherReq = owner ? req0 : req1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            rr          <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            aq          <= '0;
            read        <= 1'b0;
            wq          <= '0;
            selDCache   <= 1'b0;
            selDCacheIO <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        owner       <= grant1;
                        aq          <= grant1 ? addr1  : addr0;
                        read        <= grant1 ? read1  : read0;
                        wq          <= grant1 ? wdata1 : wdata0;
                        selDCacheIO <= grant1 ? io1    : io0;
                        selDCache   <= grant1 ? ~io1   : ~io0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // Cache misses can take arbitrarily long; no timeout.
                    if (done) begin
                        selDCache   <= 1'b0;
                        selDCacheIO <= 1'b0;
                        ack0        <= ~owner;
                        ack1        <= owner;
                        if (wrq) begin
                            if (owner) rdata1 <= rqDCache;
                            else       rdata0 <= rqDCache;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    rr    <= ~owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            waitCnt <= '0;
        else if (state != IDLE && otherReq && waitCnt != 8'hFF)
            waitCnt <= waitCnt + 8'd1;
    end

endmodule
